// File: rtl/delay_scan_pkg.sv
// Shared types and constants for the delay eye-scan sequencer.
// The tap type matches the 9-bit delay controller interface.
package delay_scan_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SET,
    WAIT_RDY,
    SETTLE,
    CLR,
    DWELL,
    EVAL,
    CALC,
    APPLY,
    FAILSET,
    DONE
  } scan_state_t;

  typedef logic [8:0] tap_t;

  localparam int TAP_W   = 9;
  // Sized for the dwell watchdog, which runs to TIMEOUT_CYCLES*256 cycles.
  localparam int TIMER_W = 24;
  // Enough for DELAY_STEP=1 across the full 512-tap range.
  localparam int RUN_W   = 10;

endpackage

// File: rtl/eye_window_tracker.sv
// Tracks the current passing run and the widest passing window seen during a scan.
// Produces the window centre (rounded down) and its width in taps.
module eye_window_tracker
  import delay_scan_pkg::*;
#(
  parameter int DELAY_STEP = 8
) (
  input  logic             clk160,
  input  logic             rstb,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  tap_t             tap,
  output logic [RUN_W-1:0] best_len,
  output tap_t             centre,
  output tap_t             width
);

  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] best_len_q, best_len_d;
  tap_t             run_start_q, run_start_d;
  tap_t             best_start_q, best_start_d;
  logic [19:0]      span;
  logic [19:0]      full_width;

  // A strictly longer run replaces the best, so the earliest window wins a tie.
  always_comb begin
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    if (clear) begin
      run_len_d    = '0;
      run_start_d  = '0;
      best_len_d   = '0;
      best_start_d = '0;
    end else if (eval) begin
      if (pass) begin
        run_len_d = run_len_q + RUN_W'(1);
        if (run_len_q == '0) begin
          run_start_d = tap;
        end
      end else begin
        run_len_d = '0;
      end
      if (run_len_d > best_len_q) begin
        best_len_d   = run_len_d;
        best_start_d = run_start_d;
      end
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else begin
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
    end
  end

  // A full-range pass would be 512 taps wide; that saturates to the 9-bit maximum.
  always_comb begin
    span       = 20'(best_len_q - RUN_W'(1)) * 20'(DELAY_STEP);
    full_width = 20'(best_len_q) * 20'(DELAY_STEP);
    centre     = best_start_q + tap_t'(span >> 1);
    width      = (full_width > 20'd511) ? 9'h1FF : full_width[8:0];
    best_len   = best_len_q;
  end

endmodule

// File: rtl/delay_scan_ctrl.sv
// Eye-scan sequencer: sweeps the P-side delay, dwells at each tap counting errors,
// then loads the centre of the widest passing window (or FAIL_DELAY on failure).
module delay_scan_ctrl
  import delay_scan_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 32,
  parameter int DELAY_STEP     = 8,
  parameter int DELAY_MAX      = 504,
  parameter int DWELL_BITS     = 65536,
  parameter int ERR_THRESH     = 0,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FAIL_DELAY     = 0
) (
  input  logic                     clk160,
  input  logic                     rstb,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     scan_fail,
  output logic [8:0]               best_delay,
  output logic [8:0]               best_width,
  output logic                     delay_set,
  output logic                     delay_mode,
  output logic [8:0]               delay_in,
  input  logic                     delay_ready,
  output logic                     reset_counters,
  input  logic [COUNTER_WIDTH-1:0] error_counter,
  input  logic [COUNTER_WIDTH-1:0] bit_counter
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LAST   = TIMER_W'(TIMEOUT_CYCLES * 256 - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLR_LAST     = TIMER_W'(2);
  localparam logic [TIMER_W-1:0] RDY_FIRST    = TIMER_W'(2);
  localparam logic [9:0]         TAP_LAST     = 10'(DELAY_MAX);
  localparam logic [9:0]         TAP_INC      = 10'(DELAY_STEP);
  localparam tap_t               FAIL_TAP     = tap_t'(FAIL_DELAY);

  scan_state_t        state_q, state_d;
  logic [9:0]         tap_q, tap_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  tap_t               delay_in_q, delay_in_d;
  logic               scan_fail_q, scan_fail_d;
  tap_t               best_delay_q, best_delay_d;
  tap_t               best_width_q, best_width_d;

  logic               trk_clear;
  logic               trk_eval;
  logic               trk_pass;
  logic [RUN_W-1:0]   trk_best_len;
  tap_t               trk_centre;
  tap_t               trk_width;

  assign trk_pass = (error_counter <= COUNTER_WIDTH'(ERR_THRESH));

  eye_window_tracker #(
    .DELAY_STEP (DELAY_STEP)
  ) u_tracker (
    .clk160   (clk160),
    .rstb     (rstb),
    .clear    (trk_clear),
    .eval     (trk_eval),
    .pass     (trk_pass),
    .tap      (tap_t'(tap_q)),
    .best_len (trk_best_len),
    .centre   (trk_centre),
    .width    (trk_width)
  );

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      timer_q      <= '0;
      delay_in_q   <= '0;
      scan_fail_q  <= 1'b0;
      best_delay_q <= '0;
      best_width_q <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      timer_q      <= timer_d;
      delay_in_q   <= delay_in_d;
      scan_fail_q  <= scan_fail_d;
      best_delay_q <= best_delay_d;
      best_width_q <= best_width_d;
    end
  end

  // delay_in is loaded on entry to each load state so it is valid with the strobe.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    timer_d      = timer_q;
    delay_in_d   = delay_in_q;
    scan_fail_d  = scan_fail_q;
    best_delay_d = best_delay_q;
    best_width_d = best_width_q;
    trk_clear    = 1'b0;
    trk_eval     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SET;
          tap_d       = '0;
          delay_in_d  = '0;
          scan_fail_d = 1'b0;
          trk_clear   = 1'b1;
        end
      end
      SET: begin
        timer_d = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        timer_d = timer_q + TIMER_W'(1);
        if ((timer_q != '0) && delay_ready) begin
          state_d = SETTLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d     = FAILSET;
          scan_fail_d = 1'b1;
          delay_in_d  = FAIL_TAP;
          timer_d     = '0;
        end
      end
      SETTLE: begin
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == SETTLE_LAST) begin
          state_d = CLR;
          timer_d = '0;
        end
      end
      CLR: begin
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == CLR_LAST) begin
          state_d = DWELL;
          timer_d = '0;
        end
      end
      DWELL: begin
        timer_d = timer_q + TIMER_W'(1);
        if (bit_counter >= COUNTER_WIDTH'(DWELL_BITS)) begin
          state_d = EVAL;
        end else if (timer_q == DWELL_LAST) begin
          state_d     = FAILSET;
          scan_fail_d = 1'b1;
          delay_in_d  = FAIL_TAP;
          timer_d     = '0;
        end
      end
      EVAL: begin
        trk_eval = 1'b1;
        if (tap_q == TAP_LAST) begin
          state_d = CALC;
        end else begin
          tap_d      = tap_q + TAP_INC;
          delay_in_d = tap_t'(tap_q + TAP_INC);
          state_d    = SET;
        end
      end
      CALC: begin
        timer_d = '0;
        if (trk_best_len == '0) begin
          state_d     = FAILSET;
          scan_fail_d = 1'b1;
          delay_in_d  = FAIL_TAP;
        end else begin
          state_d    = APPLY;
          delay_in_d = trk_centre;
        end
      end
      APPLY: begin
        timer_d = timer_q + TIMER_W'(1);
        if (((timer_q >= RDY_FIRST) && delay_ready) || (timer_q == TIMEOUT_LAST)) begin
          state_d      = DONE;
          best_delay_d = delay_in_q;
          best_width_d = trk_width;
          if (!((timer_q >= RDY_FIRST) && delay_ready)) begin
            scan_fail_d = 1'b1;
          end
        end
      end
      FAILSET: begin
        timer_d = timer_q + TIMER_W'(1);
        if (((timer_q >= RDY_FIRST) && delay_ready) || (timer_q == TIMEOUT_LAST)) begin
          state_d      = DONE;
          best_delay_d = FAIL_TAP;
          best_width_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && !(state_q inside {IDLE, FAILSET, DONE})) begin
      state_d     = FAILSET;
      scan_fail_d = 1'b1;
      delay_in_d  = FAIL_TAP;
      timer_d     = '0;
      trk_eval    = 1'b0;
    end
  end

  always_comb begin
    busy           = !(state_q inside {IDLE, DONE});
    done           = (state_q == DONE);
    delay_set      = (state_q == SET) ||
                     ((state_q inside {APPLY, FAILSET}) && (timer_q == '0));
    reset_counters = (state_q == CLR) && (timer_q == '0);
    delay_mode     = 1'b0;
    delay_in       = delay_in_q;
    scan_fail      = scan_fail_q;
    best_delay     = best_delay_q;
    best_width     = best_width_q;
  end

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Self-checking bench for delay_scan_ctrl: an emulated delay controller and error
// counters drive the DUT, and a window-search model predicts each scan's result.
module tb_delay_scan_ctrl;

  localparam int STEP       = 64;
  localparam int DMAX       = 448;
  localparam int DWELL      = 100;
  localparam int NPTS       = DMAX / STEP + 1;
  localparam int SCAN_LIMIT = 20000;

  typedef struct {
    int delay;
    int width;
    bit fail;
  } result_t;

  logic        clk160 = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        delay_ready = 1'b0;
  logic [31:0] error_counter = '0;
  logic [31:0] bit_counter = '0;
  logic        busy, done, scan_fail, delay_set, delay_mode, reset_counters;
  logic [8:0]  best_delay, best_width, delay_in;

  delay_scan_ctrl #(
    .COUNTER_WIDTH  (32),
    .DELAY_STEP     (STEP),
    .DELAY_MAX      (DMAX),
    .DWELL_BITS     (DWELL),
    .ERR_THRESH     (0),
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (4096),
    .FAIL_DELAY     (0)
  ) dut (
    .clk160         (clk160),
    .rstb           (rstb),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .scan_fail      (scan_fail),
    .best_delay     (best_delay),
    .best_width     (best_width),
    .delay_set      (delay_set),
    .delay_mode     (delay_mode),
    .delay_in       (delay_in),
    .delay_ready    (delay_ready),
    .reset_counters (reset_counters),
    .error_counter  (error_counter),
    .bit_counter    (bit_counter)
  );

  always #3 clk160 = ~clk160;

  int pass_cnt = 0;
  int check_cnt = 0;

  bit [NPTS-1:0] pass_map = '0;
  int block_tap = -1;
  int cur_tap = 0;
  int ready_cnt = 0;
  int set_count = 0;
  int cycle = 0;
  int last_set_cycle = 0;
  int last_set_val = 0;
  int block_set_cycle = 0;

  bit model_active = 1'b0;
  int done_count = 0;
  int exp_delay = 0;
  int exp_width = 0;
  int exp_fail = 0;
  int exp_strobes = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic bit tapPasses(input int t);
    if ((t % STEP) == 0 && (t / STEP) < NPTS) return pass_map[t / STEP];
    return 1'b0;
  endfunction

  // Exhaustive search over every [s,e] window; strict '>' keeps the earliest on a tie.
  function automatic result_t modelScan(input bit [NPTS-1:0] pm);
    result_t r;
    int blen = 0;
    int bstart = 0;
    bit all_pass;
    for (int s = 0; s < NPTS; s++) begin
      for (int e = s; e < NPTS; e++) begin
        all_pass = 1'b1;
        for (int i = s; i <= e; i++) if (!pm[i]) all_pass = 1'b0;
        if (all_pass && (e - s + 1) > blen) begin
          blen = e - s + 1;
          bstart = s;
        end
      end
    end
    if (blen == 0) begin
      r.delay = 0;
      r.width = 0;
      r.fail  = 1'b1;
    end else begin
      r.delay = bstart * STEP + ((blen - 1) * STEP) / 2;
      r.width = (blen * STEP > 511) ? 511 : blen * STEP;
      r.fail  = 1'b0;
    end
    return r;
  endfunction

  // Emulated delay controller and channel counters, updated away from the active edge.
  initial forever begin
    @(negedge clk160);
    cycle++;
    if (delay_set) begin
      set_count++;
      cur_tap = int'(delay_in);
      last_set_cycle = cycle;
      last_set_val = cur_tap;
      delay_ready = 1'b0;
      if (cur_tap == block_tap) begin
        ready_cnt = -1;
        block_set_cycle = cycle;
      end else begin
        ready_cnt = $urandom_range(1, 6);
      end
    end else if (ready_cnt > 0) begin
      ready_cnt--;
      if (ready_cnt == 0) delay_ready = 1'b1;
    end
    if (reset_counters) begin
      bit_counter = '0;
      error_counter = '0;
    end else begin
      bit_counter = bit_counter + 32'($urandom_range(1, 8));
      error_counter = tapPasses(cur_tap) ? 32'd0 : 32'd5;
    end
  end

  // Per-cycle comparison of busy/strobes, and of the scan result whenever done pulses.
  initial forever begin
    @(negedge clk160);
    checkOutput("delay_mode", int'(delay_mode), 0);
    if (!rstb) begin
      checkOutput("busy_in_reset", int'(busy), 0);
      model_active = 1'b0;
    end else if (done) begin
      checkOutput("busy_at_done", int'(busy), 0);
      checkOutput("done_only_when_scanning", int'(model_active), 1);
      checkOutput("scan_fail", int'(scan_fail), exp_fail);
      checkOutput("best_delay", int'(best_delay), exp_delay);
      checkOutput("best_width", int'(best_width), exp_width);
      checkOutput("delay_set_count", set_count, exp_strobes);
      done_count++;
      model_active = 1'b0;
    end else begin
      checkOutput("busy", int'(busy), int'(model_active));
      if (!model_active) begin
        checkOutput("idle_delay_set", int'(delay_set), 0);
        checkOutput("idle_reset_counters", int'(reset_counters), 0);
        if (start) model_active = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input bit with_abort);
    @(posedge clk160);
    #2;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk160);
    #2;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < SCAN_LIMIT) begin
      @(negedge clk160);
      n++;
      if (done) seen = 1'b1;
    end
    checkOutput({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic waitTap128Clear(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk160);
      n++;
      if (reset_counters && delay_in == 9'd128) seen = 1'b1;
    end
    checkOutput({name, "_reached_tap128"}, int'(seen), 1);
  endtask

  task automatic runScan(input string name, input bit with_abort);
    result_t r;
    int dc;
    r = modelScan(pass_map);
    exp_delay = r.delay;
    exp_width = r.width;
    exp_fail = int'(r.fail);
    exp_strobes = NPTS + 1;
    set_count = 0;
    dc = done_count;
    applyStimulus(with_abort);
    waitDone(name);
    repeat (3) @(negedge clk160);
    checkOutput({name, "_done_pulses"}, done_count - dc, 1);
  endtask

  initial begin
    int dc;
    int span;

    repeat (3) @(negedge clk160);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_scan_fail", int'(scan_fail), 0);
    checkOutput("rst_delay_set", int'(delay_set), 0);
    checkOutput("rst_reset_counters", int'(reset_counters), 0);
    checkOutput("rst_delay_in", int'(delay_in), 0);
    checkOutput("rst_best_delay", int'(best_delay), 0);
    checkOutput("rst_best_width", int'(best_width), 0);
    @(posedge clk160);
    #2 rstb = 1'b1;

    @(posedge clk160);
    #2 abort = 1'b1;
    @(posedge clk160);
    #2 abort = 1'b0;
    repeat (6) @(negedge clk160);
    checkOutput("idle_abort_no_strobe", set_count, 0);
    checkOutput("idle_abort_no_fail", int'(scan_fail), 0);

    pass_map = 8'b0011_1100;
    runScan("s1_window", 1'b0);
    checkOutput("s1_best_delay_lit", int'(best_delay), 224);
    checkOutput("s1_best_width_lit", int'(best_width), 256);
    checkOutput("s1_strobes_lit", set_count, 9);
    checkOutput("s1_scan_fail_lit", int'(scan_fail), 0);

    pass_map = 8'b0000_0000;
    runScan("s2_all_fail", 1'b0);
    checkOutput("s2_scan_fail_lit", int'(scan_fail), 1);
    checkOutput("s2_best_delay_lit", int'(best_delay), 0);
    checkOutput("s2_best_width_lit", int'(best_width), 0);

    pass_map = 8'b0011_0011;
    runScan("s3_tie", 1'b0);
    checkOutput("s3_tie_best_delay_lit", int'(best_delay), 32);
    checkOutput("s3_tie_best_width_lit", int'(best_width), 128);

    pass_map = 8'b0011_1100;
    block_tap = 192;
    exp_delay = 0;
    exp_width = 0;
    exp_fail = 1;
    exp_strobes = 5;
    set_count = 0;
    dc = done_count;
    applyStimulus(1'b0);
    waitDone("s4_timeout");
    repeat (3) @(negedge clk160);
    block_tap = -1;
    span = last_set_cycle - block_set_cycle;
    if (span >= 4096 && span <= 4100) checkOutput("s4_timeout_span", 1, 1);
    else checkOutput("s4_timeout_span", span, 4097);
    checkOutput("s4_failset_tap", last_set_val, 0);
    checkOutput("s4_done_pulses", done_count - dc, 1);

    exp_delay = 0;
    exp_width = 0;
    exp_fail = 1;
    exp_strobes = 4;
    set_count = 0;
    dc = done_count;
    applyStimulus(1'b0);
    waitTap128Clear("s5_abort");
    repeat (4) @(posedge clk160);
    #2 abort = 1'b1;
    @(posedge clk160);
    #2;
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk160);
    checkOutput("s5_failset_strobe", int'(delay_set), 1);
    checkOutput("s5_failset_delay_in", int'(delay_in), 0);
    checkOutput("s5_scan_fail", int'(scan_fail), 1);
    @(posedge clk160);
    #2 start = 1'b0;
    waitDone("s5_abort");
    repeat (40) @(negedge clk160);
    checkOutput("s5_no_restart_strobes", set_count, 4);
    checkOutput("s5_done_pulses", done_count - dc, 1);

    pass_map = 8'b0111_0000;
    runScan("s3_later", 1'b1);
    checkOutput("s3_later_best_delay_lit", int'(best_delay), 320);
    checkOutput("s3_later_best_width_lit", int'(best_width), 192);

    pass_map = 8'b0011_1100;
    applyStimulus(1'b0);
    waitTap128Clear("s6_reset");
    repeat (4) @(posedge clk160);
    #2 rstb = 1'b0;
    #1;
    checkOutput("s6_busy", int'(busy), 0);
    checkOutput("s6_done", int'(done), 0);
    checkOutput("s6_scan_fail", int'(scan_fail), 0);
    checkOutput("s6_delay_set", int'(delay_set), 0);
    checkOutput("s6_reset_counters", int'(reset_counters), 0);
    checkOutput("s6_delay_in", int'(delay_in), 0);
    checkOutput("s6_best_delay", int'(best_delay), 0);
    checkOutput("s6_best_width", int'(best_width), 0);
    repeat (3) @(posedge clk160);
    #2 rstb = 1'b1;
    repeat (5) @(negedge clk160);
    runScan("s6_post_reset", 1'b0);
    checkOutput("s6_best_delay_lit", int'(best_delay), 224);
    checkOutput("s6_best_width_lit", int'(best_width), 256);
    checkOutput("s6_strobes_lit", set_count, 9);

    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) pass_map = NPTS'($urandom);
      else pass_map = NPTS'($urandom | $urandom);
      $display("[TB] random scan %0d pass_map=%b", k, pass_map);
      runScan("random", 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
